spi_flash_seq: RTL and testbench

Command sequencer that sits between a requester (boot loader or memory-mapped flash window) and the SPI byte engine (TX/RX shift path with chip-select control). It accepts one flash read command at a time and issues the opcode, the address bytes MSB first, the dummy bytes and the data-read bytes to the engine. Returned data bytes go back to the requester. Chip select is held active across the whole frame.

---
 rtl/spi_flash_seq_pkg.sv | 18 +
 rtl/spi_flash_seq_flopenr.sv | 14 +
 rtl/spi_flash_seq.sv | 144 ++++++++++++++
 tb/tb_spi_flash_seq.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/spi_flash_seq_pkg.sv
// spi_flash_seq_pkg: sequencer states, SPI flash opcodes and the default filler byte.
package spi_flash_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_DONE
    } spi_seq_state_t;

    localparam logic [7:0] SPI_OP_READ      = 8'h03;
    localparam logic [7:0] SPI_OP_FAST_READ = 8'h0B;
    localparam logic [7:0] SPI_OP_RDSR      = 8'h05;
    localparam logic [7:0] SPI_DUMMY_BYTE   = 8'h00;

endpackage

// File: rtl/spi_flash_seq_flopenr.sv
// flopenr: enabled register with synchronous active-high reset.
module flopenr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk)
        if (reset) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/spi_flash_seq.sv
// spi_flash_seq: issues opcode, address, dummy and data-read bytes of one flash read
// command to a SPI byte engine and forwards the returned data bytes to the requester.
module spi_flash_seq
    import spi_flash_seq_pkg::*;
#(
    parameter int         ADDR_BYTES = 3,
    parameter int         LEN_WIDTH  = 8,
    parameter logic [7:0] DUMMY_BYTE = SPI_DUMMY_BYTE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ReqValid,
    output logic                    ReqReady,
    input  logic [7:0]              ReqOpcode,
    input  logic [8*ADDR_BYTES-1:0] ReqAddr,
    input  logic [3:0]              ReqDummy,
    input  logic [LEN_WIDTH-1:0]    ReqLen,
    input  logic                    Abort,
    output logic                    RspValid,
    output logic [7:0]              RspData,
    output logic                    RspLast,
    output logic                    Busy,
    output logic                    ByteTxValid,
    input  logic                    ByteTxReady,
    output logic [7:0]              ByteTxData,
    input  logic                    ByteRxValid,
    input  logic [7:0]              ByteRxData,
    output logic                    CsHold
);
    spi_seq_state_t r_state, w_next_state, w_after_addr, w_after_dummy, w_phase_next;
    logic r_wait, w_next_wait, r_abort, w_next_abort;
    logic [7:0] r_op;
    logic [8*ADDR_BYTES-1:0] r_addr, w_addr_sh;
    logic [3:0] r_dummy, r_dcnt, w_dcnt_d;
    logic [LEN_WIDTH-1:0] r_len, r_lcnt, w_lcnt_d;
    logic [1:0] r_acnt, w_acnt_d;
    logic r_rsp_valid, r_rsp_last;
    logic [7:0] r_rsp_data;
    logic w_idle, w_phase, w_send, w_hs, w_byte_done, w_abort, w_fwd;
    logic w_last_addr, w_last_dummy, w_last_data, w_phase_last;

    assign w_idle       = r_state == S_IDLE;
    assign w_phase      = (r_state == S_CMD) | (r_state == S_ADDR) | (r_state == S_DUMMY) | (r_state == S_DATA);
    assign w_send       = w_phase & ~r_wait;
    assign w_hs         = w_send & ByteTxReady;
    assign w_byte_done  = (w_hs | (w_phase & r_wait)) & ByteRxValid;
    assign w_abort      = r_abort | Abort;
    assign w_last_addr  = r_acnt == 2'(ADDR_BYTES - 1);
    assign w_last_dummy = r_dcnt == r_dummy - 4'd1;
    assign w_last_data  = r_lcnt == r_len - LEN_WIDTH'(1);
    assign w_phase_last = (r_state == S_CMD) ? 1'b1 :
                          (r_state == S_ADDR) ? w_last_addr :
                          (r_state == S_DUMMY) ? w_last_dummy : w_last_data;
    assign w_after_dummy = (r_len != '0) ? S_DATA : S_DONE;
    assign w_after_addr  = (r_dummy != 4'd0) ? S_DUMMY : w_after_dummy;
    assign w_phase_next  = !w_phase_last ? r_state :
                           (r_state == S_CMD) ? S_ADDR :
                           (r_state == S_ADDR) ? w_after_addr :
                           (r_state == S_DUMMY) ? w_after_dummy : S_DONE;
    assign w_fwd = (r_state == S_DATA) & w_byte_done & ~w_abort;

    always_comb begin
        w_next_state = r_state;
        w_next_wait  = r_wait;
        w_next_abort = r_abort;
        if (w_idle) begin
            w_next_abort = 1'b0;
            w_next_wait  = 1'b0;
            if (ReqValid) w_next_state = S_CMD;
        end else if (r_state == S_DONE) begin
            w_next_state = S_IDLE;
        end else begin
            w_next_abort = w_abort;
            // An unaccepted byte can be withdrawn; an accepted one must see its RX byte first.
            if (w_send & Abort & ~ByteTxReady) begin
                w_next_state = S_DONE;
            end else if (w_byte_done) begin
                w_next_wait  = 1'b0;
                w_next_state = w_abort ? S_DONE : w_phase_next;
            end else if (w_hs) begin
                w_next_wait = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_wait      <= 1'b0;
            r_abort     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_rsp_data  <= 8'h00;
        end else begin
            r_state     <= w_next_state;
            r_wait      <= w_next_wait;
            r_abort     <= w_next_abort;
            r_rsp_valid <= w_fwd;
            r_rsp_last  <= w_fwd & w_last_data;
            r_rsp_data  <= w_fwd ? ByteRxData : r_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op    <= 8'h00;
            r_addr  <= '0;
            r_dummy <= 4'd0;
            r_len   <= '0;
        end else if (w_idle & ReqValid) begin
            r_op    <= ReqOpcode;
            r_addr  <= ReqAddr;
            r_dummy <= ReqDummy;
            r_len   <= ReqLen;
        end
    end

    // Counters clear while idle and on the last byte of their phase.
    assign w_acnt_d = (r_state == S_ADDR & ~w_last_addr) ? r_acnt + 2'd1 : 2'd0;
    assign w_dcnt_d = (r_state == S_DUMMY & ~w_last_dummy) ? r_dcnt + 4'd1 : 4'd0;
    assign w_lcnt_d = (r_state == S_DATA & ~w_last_data) ? r_lcnt + LEN_WIDTH'(1) : '0;

    flopenr #(.WIDTH(2)) u_acnt (
        .clk(clk), .reset(reset), .en(w_idle | (r_state == S_ADDR & w_byte_done)),
        .d(w_acnt_d), .q(r_acnt));
    flopenr #(.WIDTH(4)) u_dcnt (
        .clk(clk), .reset(reset), .en(w_idle | (r_state == S_DUMMY & w_byte_done)),
        .d(w_dcnt_d), .q(r_dcnt));
    flopenr #(.WIDTH(LEN_WIDTH)) u_lcnt (
        .clk(clk), .reset(reset), .en(w_idle | (r_state == S_DATA & w_byte_done)),
        .d(w_lcnt_d), .q(r_lcnt));

    assign w_addr_sh   = r_addr << {r_acnt, 3'b000};
    assign ReqReady    = w_idle;
    assign Busy        = ~w_idle;
    assign CsHold      = w_phase;
    assign ByteTxValid = w_send;
    assign ByteTxData  = !w_send ? 8'h00 :
                         (r_state == S_CMD) ? r_op :
                         (r_state == S_ADDR) ? w_addr_sh[8*ADDR_BYTES-1 -: 8] : DUMMY_BYTE;
    assign RspValid    = r_rsp_valid;
    assign RspData     = r_rsp_data;
    assign RspLast     = r_rsp_last;
endmodule

// File: tb/tb_spi_flash_seq.sv
// tb_spi_flash_seq: directed scenarios against a cycle-level SPI byte engine model.
module tb_spi_flash_seq;
    logic clk = 1'b0;
    logic reset, ReqValid, ReqReady, Abort, RspValid, RspLast, Busy;
    logic ByteTxValid, ByteTxReady, ByteRxValid, CsHold;
    logic [7:0] ReqOpcode, RspData, ByteTxData, ByteRxData;
    logic [23:0] ReqAddr;
    logic [3:0] ReqDummy;
    logic [7:0] ReqLen;

    int errors = 0;
    int checks = 0;
    logic [63:0] tx_cat;
    logic [31:0] rsp_cat;
    logic [21:0] rst_snap;
    int tx_n, rsp_n, last_n, last_at, cs_drops, txv_wait, unstable, done_cyc, gap, stall_left;
    logic timeout, ready_at_accept, cs_after_accept;

    always #5 clk = ~clk;

    spi_flash_seq dut (
        .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
        .ReqOpcode(ReqOpcode), .ReqAddr(ReqAddr), .ReqDummy(ReqDummy), .ReqLen(ReqLen),
        .Abort(Abort), .RspValid(RspValid), .RspData(RspData), .RspLast(RspLast),
        .Busy(Busy), .ByteTxValid(ByteTxValid), .ByteTxReady(ByteTxReady),
        .ByteTxData(ByteTxData), .ByteRxValid(ByteRxValid), .ByteRxData(ByteRxData),
        .CsHold(CsHold)
    );

    // Issues one request and plays the engine until ReqReady returns.
    // lat=0 answers in the accept cycle; stall_n cycles of ReadyLow on the byte stall_val;
    // abort_tx/reset_tx fire once the given number of TX bytes has been accepted.
    task automatic run_cmd(input logic [7:0] op, input logic [23:0] addr, input logic [3:0] dum,
                           input logic [7:0] len, input int lat, input logic [7:0] stall_val,
                           input int stall_n, input int abort_tx, input int reset_tx);
        int lat_cnt = 0, last_rx = 0, rx_idx = 0;
        bit pend = 0, aborted = 0, stalling = 0, prev_cs;
        tx_cat = '0; rsp_cat = '0; tx_n = 0; rsp_n = 0; last_n = 0; last_at = 0;
        cs_drops = 0; txv_wait = 0; unstable = 0; done_cyc = 0; gap = -1;
        stall_left = stall_n; timeout = 1'b1;
        @(negedge clk);
        ready_at_accept = ReqReady;
        ReqValid = 1'b1; ReqOpcode = op; ReqAddr = addr; ReqDummy = dum; ReqLen = len;
        @(negedge clk);
        ReqValid = 1'b0; ReqOpcode = 8'hEE; ReqAddr = '1; ReqDummy = '1; ReqLen = '1;
        cs_after_accept = Busy & CsHold;
        prev_cs = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (reset_tx > 0 && tx_n >= reset_tx) begin
                ByteTxReady = 1'b0; ByteRxValid = 1'b0; Abort = 1'b0; reset = 1'b1;
                @(negedge clk);
                rst_snap = {ReqReady, Busy, CsHold, ByteTxValid, RspValid, RspLast, ByteTxData, RspData};
                reset = 1'b0; timeout = 1'b0;
                return;
            end
            if (RspValid) begin
                rsp_cat = {rsp_cat[23:0], RspData}; rsp_n++;
                if (RspLast) begin last_n++; last_at = rsp_n; end
            end
            if (prev_cs && !CsHold) cs_drops++;
            prev_cs = CsHold;
            if (Busy && !CsHold) done_cyc++;
            if (stalling && (!ByteTxValid || ByteTxData !== stall_val)) unstable++;
            if (ReqReady) begin gap = c - last_rx; timeout = 1'b0; break; end
            Abort = (abort_tx > 0 && tx_n == abort_tx && !aborted);
            if (Abort) aborted = 1;
            ByteRxValid = 1'b0; ByteTxReady = 1'b0; stalling = 0;
            if (pend) begin
                if (ByteTxValid) txv_wait++;
                if (lat_cnt == 1) begin ByteRxValid = 1'b1; pend = 0; end
                else lat_cnt--;
            end else if (ByteTxValid) begin
                if (stall_left > 0 && ByteTxData == stall_val) begin
                    stall_left--; stalling = 1;
                end else begin
                    ByteTxReady = 1'b1; tx_cat = {tx_cat[55:0], ByteTxData}; tx_n++;
                    if (lat == 0) ByteRxValid = 1'b1;
                    else begin pend = 1; lat_cnt = lat; end
                end
            end
            if (ByteRxValid) begin ByteRxData = 8'hA0 + 8'(rx_idx); rx_idx++; last_rx = c; end
            @(negedge clk);
        end
        ByteTxReady = 1'b0; ByteRxValid = 1'b0; Abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ReqValid = 1'b0; ReqOpcode = 8'h00; ReqAddr = '0; ReqDummy = '0; ReqLen = '0;
        Abort = 1'b0; ByteTxReady = 1'b0; ByteRxValid = 1'b0; ByteRxData = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rst_snap = {ReqReady, Busy, CsHold, ByteTxValid, RspValid, RspLast, ByteTxData, RspData};
        checks++; if (rst_snap !== 22'h200000) begin errors++; $display("FAIL reset_outputs got=%h exp=%h", rst_snap, 22'h200000); end
        Abort = 1'b1; ByteRxValid = 1'b1; ByteRxData = 8'h55;
        @(negedge clk);
        Abort = 1'b0; ByteRxValid = 1'b0;
        @(negedge clk);
        rst_snap = {ReqReady, Busy, CsHold, ByteTxValid, RspValid, RspLast, ByteTxData, RspData};
        checks++; if (rst_snap !== 22'h200000) begin errors++; $display("FAIL idle_ignores_abort_rx got=%h exp=%h", rst_snap, 22'h200000); end
    endtask

    task automatic test_read_zero_wait();
        run_cmd(8'h03, 24'h123456, 4'd0, 8'd2, 0, 8'h00, 0, 0, 0);
        checks++; if (ready_at_accept !== 1'b1) begin errors++; $display("FAIL read_ready got=%b exp=1", ready_at_accept); end
        checks++; if (cs_after_accept !== 1'b1) begin errors++; $display("FAIL read_cs_rise got=%b exp=1", cs_after_accept); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL read_timeout got=%b exp=0", timeout); end
        checks++; if (tx_n !== 6 || tx_cat !== 64'h0000_0312_3456_0000) begin errors++; $display("FAIL read_tx got=%0d/%h exp=6/%h", tx_n, tx_cat, 64'h0000_0312_3456_0000); end
        checks++; if (rsp_n !== 2 || rsp_cat !== 32'h0000_A4A5) begin errors++; $display("FAIL read_rsp got=%0d/%h exp=2/0000a4a5", rsp_n, rsp_cat); end
        checks++; if (last_n !== 1 || last_at !== 2) begin errors++; $display("FAIL read_last got=%0d@%0d exp=1@2", last_n, last_at); end
        checks++; if (cs_drops !== 1) begin errors++; $display("FAIL read_cs_continuous got=%0d exp=1", cs_drops); end
        checks++; if (gap !== 2) begin errors++; $display("FAIL read_gap got=%0d exp=2", gap); end
    endtask

    task automatic test_fast_read_latency();
        run_cmd(8'h0B, 24'h000010, 4'd1, 8'd1, 8, 8'h00, 0, 0, 0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL fast_timeout got=%b exp=0", timeout); end
        checks++; if (tx_n !== 6 || tx_cat !== 64'h0000_0B00_0010_0000) begin errors++; $display("FAIL fast_tx got=%0d/%h exp=6/%h", tx_n, tx_cat, 64'h0000_0B00_0010_0000); end
        checks++; if (rsp_n !== 1 || rsp_cat !== 32'h0000_00A5 || last_at !== 1) begin errors++; $display("FAIL fast_rsp got=%0d/%h/%0d exp=1/000000a5/1", rsp_n, rsp_cat, last_at); end
        checks++; if (txv_wait !== 0) begin errors++; $display("FAIL fast_txvalid_in_wait got=%0d exp=0", txv_wait); end
    endtask

    task automatic test_rdsr_no_data();
        run_cmd(8'h05, 24'h000000, 4'd0, 8'd0, 1, 8'h00, 0, 0, 0);
        checks++; if (tx_n !== 4 || tx_cat !== 64'h0000_0000_0500_0000) begin errors++; $display("FAIL rdsr_tx got=%0d/%h exp=4/%h", tx_n, tx_cat, 64'h0500_0000); end
        checks++; if (rsp_n !== 0) begin errors++; $display("FAIL rdsr_rsp got=%0d exp=0", rsp_n); end
        checks++; if (done_cyc !== 1) begin errors++; $display("FAIL rdsr_done_len got=%0d exp=1", done_cyc); end
        checks++; if (gap !== 2) begin errors++; $display("FAIL rdsr_gap got=%0d exp=2", gap); end
    endtask

    task automatic test_tx_stall();
        run_cmd(8'h03, 24'h123456, 4'd0, 8'd1, 1, 8'h34, 5, 0, 0);
        checks++; if (tx_n !== 5 || tx_cat !== 64'h0000_0003_1234_5600) begin errors++; $display("FAIL stall_tx got=%0d/%h exp=5/%h", tx_n, tx_cat, 64'h03_1234_5600); end
        checks++; if (unstable !== 0 || stall_left !== 0) begin errors++; $display("FAIL stall_stable got=%0d/%0d exp=0/0", unstable, stall_left); end
        checks++; if (rsp_n !== 1 || rsp_cat !== 32'h0000_00A4 || last_at !== 1) begin errors++; $display("FAIL stall_rsp got=%0d/%h/%0d exp=1/000000a4/1", rsp_n, rsp_cat, last_at); end
    endtask

    task automatic test_abort_data();
        run_cmd(8'h03, 24'h123456, 4'd0, 8'd4, 3, 8'h00, 0, 6, 0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL abort_timeout got=%b exp=0", timeout); end
        checks++; if (tx_n !== 6) begin errors++; $display("FAIL abort_tx_count got=%0d exp=6", tx_n); end
        checks++; if (rsp_n !== 1 || rsp_cat !== 32'h0000_00A4) begin errors++; $display("FAIL abort_rsp got=%0d/%h exp=1/000000a4", rsp_n, rsp_cat); end
        checks++; if (last_n !== 0) begin errors++; $display("FAIL abort_last got=%0d exp=0", last_n); end
        checks++; if (cs_drops !== 1 || done_cyc !== 1) begin errors++; $display("FAIL abort_cs got=%0d/%0d exp=1/1", cs_drops, done_cyc); end
    endtask

    task automatic test_abort_send();
        run_cmd(8'h03, 24'h123456, 4'd0, 8'd2, 0, 8'h56, 5, 3, 0);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL abort_send_timeout got=%b exp=0", timeout); end
        checks++; if (tx_n !== 3 || tx_cat !== 64'h0000_0000_0003_1234) begin errors++; $display("FAIL abort_send_tx got=%0d/%h exp=3/%h", tx_n, tx_cat, 64'h03_1234); end
        checks++; if (rsp_n !== 0 || done_cyc !== 1) begin errors++; $display("FAIL abort_send_end got=%0d/%0d exp=0/1", rsp_n, done_cyc); end
    endtask

    task automatic test_reset_mid_addr();
        run_cmd(8'h03, 24'h123456, 4'd0, 8'd2, 2, 8'h00, 0, 0, 2);
        checks++; if (rst_snap !== 22'h200000) begin errors++; $display("FAIL midreset_outputs got=%h exp=%h", rst_snap, 22'h200000); end
        run_cmd(8'h03, 24'hABCDEF, 4'd0, 8'd1, 0, 8'h00, 0, 0, 0);
        checks++; if (tx_n !== 5 || tx_cat !== 64'h0000_0003_ABCD_EF00) begin errors++; $display("FAIL midreset_next_tx got=%0d/%h exp=5/%h", tx_n, tx_cat, 64'h03_ABCD_EF00); end
        checks++; if (rsp_n !== 1 || rsp_cat !== 32'h0000_00A4 || last_at !== 1) begin errors++; $display("FAIL midreset_next_rsp got=%0d/%h/%0d exp=1/000000a4/1", rsp_n, rsp_cat, last_at); end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_fast_read_latency();
        test_rdsr_no_data();
        test_tx_stall();
        test_abort_data();
        test_abort_send();
        test_reset_mid_addr();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
